// File: rtl/fast_mux_pkg.sv
// Shared constants for the fast message mux: widths, the idle select code,
// the source index names and the value driven on empty output channels.
`ifndef FAST_MESSAGE_BITS
`define FAST_MESSAGE_BITS 8
`endif
`ifndef FAST_LENGTH_BITS
`define FAST_LENGTH_BITS 4
`endif
`ifndef MESSAGE_MUX_CONTROL_WIDTH
`define MESSAGE_MUX_CONTROL_WIDTH 3
`endif
`ifndef DEFAUT_FAST_MESSAGE
`define DEFAUT_FAST_MESSAGE 8'h00
`endif
`ifndef DEFAUT_FAST_LENGTH
`define DEFAUT_FAST_LENGTH 4'h0
`endif

package fast_mux_pkg;
  localparam int FAST_MSG_BITS = `FAST_MESSAGE_BITS;
  localparam int FAST_LEN_BITS = `FAST_LENGTH_BITS;
  localparam int MUX_SEL_W     = `MESSAGE_MUX_CONTROL_WIDTH;

  localparam logic [MUX_SEL_W-1:0] SEL_IDLE = '1;

  localparam int SRC_A = 0;
  localparam int SRC_D = 1;
  localparam int SRC_K = 2;
  localparam int SRC_Q = 3;
  localparam int SRC_N = 4;

  localparam logic [FAST_MSG_BITS-1:0] DEFAULT_MSG = `DEFAUT_FAST_MESSAGE;
  localparam logic [FAST_LEN_BITS-1:0] DEFAULT_LEN = `DEFAUT_FAST_LENGTH;
endpackage

// File: rtl/fast_mux_skid_buffer.sv
// Two-entry FIFO holding one channel's accepted {msg,len} words; the head
// entry is presented on o_data whenever o_valid is high.
module fast_mux_skid_buffer
  import fast_mux_pkg::*;
#(
  parameter int WIDTH = FAST_MSG_BITS + FAST_LEN_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [1:0]       o_count
);
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head_p1;
  logic [WIDTH-1:0] r_tail_p1;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) r_count <= 2'd0;
    else     r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
  end

  // Storage is not reset: entries are only visible while r_count marks them valid.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      if (r_count == 2'd2) r_head_p1 <= r_tail_p1;
      else if (w_push)     r_head_p1 <= i_data;
    end else if (w_push) begin
      if (r_count == 2'd0) r_head_p1 <= i_data;
      else                 r_tail_p1 <= i_data;
    end
  end

  assign o_data  = r_head_p1;
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;
endmodule

// File: rtl/fast_message_mux_pipe.sv
// Per-channel source mux feeding a 2-entry buffer, with illegal-select
// detection and a saturating error counter; channels are fully independent.
module fast_message_mux_pipe
  import fast_mux_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int SOURCES  = 5,
  parameter int MSG_BITS = FAST_MSG_BITS,
  parameter int LEN_BITS = FAST_LEN_BITS,
  parameter int SEL_W    = MUX_SEL_W,
  parameter int CNT_W    = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CHANNELS*SOURCES-1:0]         in_valid,
  output logic [CHANNELS*SOURCES-1:0]         in_ready,
  input  logic [CHANNELS*SOURCES*MSG_BITS-1:0] in_msg,
  input  logic [CHANNELS*SOURCES*LEN_BITS-1:0] in_len,
  input  logic [CHANNELS*SEL_W-1:0]           sel,
  output logic [CHANNELS-1:0]                 out_valid,
  input  logic [CHANNELS-1:0]                 out_ready,
  output logic [CHANNELS*MSG_BITS-1:0]        out_msg,
  output logic [CHANNELS*LEN_BITS-1:0]        out_len,
  output logic [CHANNELS-1:0]                 sel_err,
  output logic [CHANNELS*CNT_W-1:0]           err_cnt
);
  localparam int               ENTRY_W = MSG_BITS + LEN_BITS;
  localparam logic [SEL_W-1:0] SEL_LIM = SEL_W'(SOURCES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SEL_W-1:0]   w_sel;
    logic               w_legal;
    logic               w_illegal;
    logic [SOURCES-1:0] w_rdy;
    logic [ENTRY_W-1:0] w_wdata_p0;
    logic [ENTRY_W-1:0] w_rdata_p1;
    logic               w_push;
    logic               w_pop;
    logic               w_vld_p1;
    logic [1:0]         w_count;
    logic [CNT_W-1:0]   r_err_cnt;

    assign w_sel     = sel[c*SEL_W +: SEL_W];
    assign w_legal   = (w_sel < SEL_LIM);
    assign w_illegal = !w_legal && !(&w_sel);

    // Ready comes only from registered occupancy and the select, never out_ready.
    always_comb begin
      w_rdy      = '0;
      w_wdata_p0 = '0;
      for (int s = 0; s < SOURCES; s++) begin
        if (w_legal && (w_sel == SEL_W'(s))) begin
          w_rdy[s]   = !rst && (w_count != 2'd2);
          w_wdata_p0 = {in_msg[(c*SOURCES+s)*MSG_BITS +: MSG_BITS],
                        in_len[(c*SOURCES+s)*LEN_BITS +: LEN_BITS]};
        end
      end
    end

    assign in_ready[c*SOURCES +: SOURCES] = w_rdy;
    assign w_push = |(w_rdy & in_valid[c*SOURCES +: SOURCES]);
    assign w_pop  = w_vld_p1 && out_ready[c];

    // ---- stage p0 -> p1: buffer write ----
    fast_mux_skid_buffer #(.WIDTH(ENTRY_W)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_wdata_p0),
      .i_pop   (w_pop),
      .o_data  (w_rdata_p1),
      .o_valid (w_vld_p1),
      .o_count (w_count)
    );

    always_ff @(posedge clk) begin
      if (rst)            r_err_cnt <= '0;
      else if (w_illegal) r_err_cnt <= sat_inc(r_err_cnt);
    end

    assign out_valid[c] = w_vld_p1;
    assign out_msg[c*MSG_BITS +: MSG_BITS] =
      w_vld_p1 ? w_rdata_p1[ENTRY_W-1 -: MSG_BITS] : MSG_BITS'(DEFAULT_MSG);
    assign out_len[c*LEN_BITS +: LEN_BITS] =
      w_vld_p1 ? w_rdata_p1[LEN_BITS-1:0] : LEN_BITS'(DEFAULT_LEN);
    assign sel_err[c] = w_illegal && !rst;
    assign err_cnt[c*CNT_W +: CNT_W] = r_err_cnt;
  end
endmodule

// File: doc/fast_message_mux_pipe.md
FAST_MESSAGE_MUX_PIPE -- requirements
Module: fast_message_mux_pipe

Interface
REQ-001 Parameter CHANNELS, default 3: number of independent output channels.
REQ-002 Parameter SOURCES, default 5: sources per channel; index 0..4 correspond to a, d, k, q, N.
REQ-003 Parameter MSG_BITS, default `fast_message_bits: message width.
REQ-004 Parameter LEN_BITS, default `fast_length_bits: length width.
REQ-005 Parameter SEL_W, default `message_mux_control_width: select width; all-ones value is SEL_IDLE.
REQ-006 Parameter CNT_W, default 16: error counter width.
REQ-007 clk  in  1  single clock; all logic on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 in_valid  in  CHANNELS*SOURCES  source-offers-message, index c*SOURCES+s.
REQ-010 in_ready  out  CHANNELS*SOURCES  channel accepts from source, same indexing.
REQ-011 in_msg  in  CHANNELS*SOURCES*MSG_BITS  source messages, flattened, same indexing.
REQ-012 in_len  in  CHANNELS*SOURCES*LEN_BITS  source lengths, same indexing.
REQ-013 sel  in  CHANNELS*SEL_W  per-channel source select.
REQ-014 out_valid  out  CHANNELS  output message valid.
REQ-015 out_ready  in  CHANNELS  downstream accepts.
REQ-016 out_msg  out  CHANNELS*MSG_BITS  selected message.
REQ-017 out_len  out  CHANNELS*LEN_BITS  selected length.
REQ-018 sel_err  out  CHANNELS  one-cycle pulse, illegal select.
REQ-019 err_cnt  out  CHANNELS*CNT_W  saturating illegal-select count.

Function
REQ-020 Each channel SHALL operate independently; no cross-channel interaction.
REQ-021 sel < SOURCES: in_ready for the selected source SHALL be 1 iff channel buffer holds fewer than 2 entries; all other sources' in_ready SHALL be 0.
REQ-022 sel == SEL_IDLE: all in_ready of that channel SHALL be 0; no error.
REQ-023 SOURCES <= sel < SEL_IDLE: all in_ready 0; sel_err SHALL pulse each cycle the condition holds; err_cnt increments by 1, saturating at all-ones.
REQ-024 Transfer on in_valid&&in_ready SHALL write {msg,len} into the channel's 2-entry FIFO; out_valid SHALL rise the next cycle (latency 1).
REQ-025 in_ready SHALL depend only on registered occupancy and sel, never on out_ready (no combinational ready path).
REQ-026 Output pop on out_valid&&out_ready; simultaneous push and pop at occupancy 1 SHALL keep occupancy 1 and preserve order.
REQ-027 Occupancy 2: in_ready 0 until a pop; no entry SHALL be overwritten or dropped.
REQ-028 out_msg/out_len SHALL hold stable while out_valid&&!out_ready.
REQ-029 out_valid 0: out_msg SHALL equal `defaut_fast_message, out_len `defaut_fast_length.
REQ-030 sel change SHALL affect only subsequent acceptance; buffered entries drain unchanged.

Reset
REQ-031 rst SHALL clear occupancy to 0, out_valid 0, sel_err 0, err_cnt 0, out_msg/out_len to defaults, in_ready 0 during reset cycle.
REQ-032 rst mid-operation SHALL discard buffered entries; first acceptance possible the cycle after rst deasserts.

Structure
REQ-033 Package fast_mux_pkg SHALL hold SEL_IDLE, source index constants (a,d,k,q,N), default message/length constants.
REQ-034 Sub-module fast_mux_skid_buffer (2-entry FIFO, width MSG_BITS+LEN_BITS) SHALL be instantiated once per channel via generate.

Verification
REQ-035 Ch0 sel=1 (d), in_valid d=1 msg=0xA5 len=4, out_ready=1 -> next cycle out_valid=1, out_msg=0xA5, out_len=4.
REQ-036 Ch1 out_ready=0, three back-to-back offers -> two accepted, in_ready 0 on third; release out_ready -> both emitted in order, third accepted.
REQ-037 Ch2 sel=5 for 3 cycles -> sel_err pulses 3 cycles, err_cnt=3, no in_ready asserted.
REQ-038 err_cnt forced near all-ones with continuous illegal sel -> holds at all-ones, no wrap.
REQ-039 Occupancy 1, push and pop same cycle -> occupancy 1, order preserved; then rst with 2 entries -> out_valid 0 next cycle, defaults on outputs.
REQ-040 sel=SEL_IDLE with all in_valid high -> all in_ready 0, no sel_err, out_valid stays 0.
